acc_cpu: RTL
============

# acc_cpu

- Parametrised successor to the four-bit accumulator CPU.
- Two general registers A and B, a carry flag, a program counter, an input port and a registered output port.
- Widths are generic: DATA_W for the datapath, ADDR_W for program memory depth.
- New over the fixed four-bit design: a writable program memory, run/single-step/halt control, and a sticky HLT instruction. These let a bench or a board-level loader drive the core without a ROM rebuild.

## Interface
- DATA_W, 4, width of A, B, immediate, in_port, out_port
- ADDR_W, 4, PC width; program memory holds 2^ADDR_W words of (4+DATA_W) bits
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high; one clock, reset is synchronous and active-high
- run  in  1  level; while high, executes one instruction per cycle
- step  in  1  single-step request; the rising edge (high now, low last cycle) executes one instruction when run=0
- prog_we  in  1  program memory write enable
- prog_addr  in  ADDR_W  program memory write address
- prog_data  in  4+DATA_W  write word: [DATA_W+3:DATA_W]=opcode, [DATA_W-1:0]=immediate
- in_port  in  DATA_W  input port, sampled in the executing cycle
- out_port  out  DATA_W  registered output port
- pc  out  ADDR_W  current program counter
- carry  out  1  carry flag
- halted  out  1  high after HLT executes, until rst

## Operation
- Fetch: combinational read of mem[pc].
- Execute enable: exec = !halted && (run || step_rise), where step_rise = step && !step_q. The step_q register is updated every cycle.
- Opcodes and effects (Im = immediate):
  - 0000 ADD A,Im: A=A+Im, carry=carry-out.
  - 0101 ADD B,Im: B=B+Im, carry=carry-out.
  - 0011 MOV A,Im.
  - 0111 MOV B,Im.
  - 0001 MOV A,B.
  - 0100 MOV B,A.
  - 0010 IN A: A=in_port.
  - 0110 IN B: B=in_port.
  - 1001 OUT B: out_port=B.
  - 1011 OUT Im: out_port=Im.
  - 1111 JMP Im.
  - 1110 JNC Im: jump only if carry==0 before this instruction.
  - 1101 HLT: halted=1, pc unchanged.
  - 1000, 1010, 1100: NOP.
- Carry: every executed non-ADD instruction clears carry, including NOP, HLT and jumps.
- Arithmetic: sums are DATA_W bits, modulo 2^DATA_W. Carry is bit DATA_W of the (DATA_W+1)-bit sum.
- Jump target: Im zero-extended or truncated to ADDR_W bits.
- Next PC: pc+1 modulo 2^ADDR_W (wraps from 2^ADDR_W-1 to 0) unless a jump is taken or the instruction is HLT.
- When exec=0: A, B, carry, pc and out_port hold.
- Program memory:
  - Written on any cycle with prog_we=1, whatever the run state.
  - Memory is not cleared by rst.
  - A write to the address being fetched in the same cycle takes effect next cycle; the current instruction uses the old word.
- Precedence: rst > halted > run > step_rise. With run=1 and step rising together, exactly one instruction executes that cycle.

## Timing
- Reset values after a rising edge with rst=1: A=0, B=0, carry=0, pc=0, out_port=0, halted=0, step_q=0.
- Reset during run aborts the in-flight instruction: no register other than reset targets changes.
- Latency: single cycle per instruction. Results are visible on outputs the cycle after the executing edge.
- Throughput: 1 instruction/clk while run=1.
- Step: one instruction per step rising edge. Holding step high executes only once.
- HLT: halted is visible the next cycle. run and step are then ignored until rst.
- in_port has no internal synchroniser; it must be synchronous to clk.

## Test plan
- Reset: drive rst=1 for 2 cycles with random prior state -> A=B=0, carry=0, pc=0, out_port=0, halted=0.
- Carry/JNC, DATA_W=4:
  - Program: MOV A,0xE; ADD A,0x3; JNC 0x0; OUT Im 0x5; HLT.
  - Required: A=0x1, carry=1, JNC not taken, out_port=0x5 at cycle 5, halted=1, pc=4 stays.
- Counter loop: ADD B,1; OUT B; JMP 0 with run=1 for 30 cycles -> out_port increments every 3 cycles and wraps 0xF->0x0.
- Step mode, run=0:
  - Hold step high 5 cycles -> exactly one instruction, pc 0->1.
  - Three separate 1-cycle pulses -> pc=4.
- PC wrap, ADDR_W=4: all 16 words NOP, run 17 cycles -> pc sequence 0..15,0,1; carry=0 throughout.
- Reset mid-run and write collision:
  - Assert rst during ADD -> A=0 next cycle, no carry set.
  - Write mem[pc] while it is fetched -> old word executes, new word executes on revisit.

Source files
------------

// File: rtl/acc_cpu_if.sv
// Bus bundle for acc_cpu: run/step control, program-load port and the
// architectural outputs. The controller (bench or board loader) is the
// master; the core is the slave.
interface acc_cpu_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
);
    logic                run;
    logic                step;
    logic                prog_we;
    logic [ADDR_W-1:0]   prog_addr;
    logic [DATA_W+3:0]   prog_data;
    logic [DATA_W-1:0]   in_port;
    logic [DATA_W-1:0]   out_port;
    logic [ADDR_W-1:0]   pc;
    logic                carry;
    logic                halted;

    modport master (
        output run, step, prog_we, prog_addr, prog_data, in_port,
        input  out_port, pc, carry, halted
    );

    modport slave (
        input  run, step, prog_we, prog_addr, prog_data, in_port,
        output out_port, pc, carry, halted
    );
endinterface

// File: rtl/acc_cpu.sv
// acc_cpu: parametrised single-cycle accumulator CPU with two registers,
// a carry flag, writable program memory, run/single-step control and a
// sticky HLT. One instruction retires per executing clock edge.
module acc_cpu #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    acc_cpu_if.slave     bus
);
    localparam int INSTR_W   = DATA_W + 4;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    typedef enum logic [3:0] {
        OP_ADD_A  = 4'b0000,
        OP_MOV_AB = 4'b0001,
        OP_IN_A   = 4'b0010,
        OP_MOV_AI = 4'b0011,
        OP_MOV_BA = 4'b0100,
        OP_ADD_B  = 4'b0101,
        OP_IN_B   = 4'b0110,
        OP_MOV_BI = 4'b0111,
        OP_NOP_8  = 4'b1000,
        OP_OUT_B  = 4'b1001,
        OP_NOP_A  = 4'b1010,
        OP_OUT_I  = 4'b1011,
        OP_NOP_C  = 4'b1100,
        OP_HLT    = 4'b1101,
        OP_JNC    = 4'b1110,
        OP_JMP    = 4'b1111
    } opcode_t;

    // Architectural state
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic               r_carry;
    logic [ADDR_W-1:0]  r_pc;
    logic [DATA_W-1:0]  r_out;
    logic               r_halted;
    logic               r_step_q;
    logic [INSTR_W-1:0] r_mem [MEM_DEPTH];

    // Fetch/decode and next-state values
    logic [INSTR_W-1:0] w_instr;
    opcode_t            w_op;
    logic [DATA_W-1:0]  w_imm;
    logic [DATA_W:0]    w_sum_a;
    logic [DATA_W:0]    w_sum_b;
    logic               w_step_rise;
    logic               w_exec;
    logic [DATA_W-1:0]  w_a_nxt;
    logic [DATA_W-1:0]  w_b_nxt;
    logic               w_carry_nxt;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [DATA_W-1:0]  w_out_nxt;
    logic               w_halted_nxt;

    // Combinational fetch: a same-cycle write lands at the edge, so the
    // instruction executing now always sees the old word.
    assign w_instr     = r_mem[r_pc];
    assign w_op        = opcode_t'(w_instr[INSTR_W-1:DATA_W]);
    assign w_imm       = w_instr[DATA_W-1:0];
    assign w_sum_a     = {1'b0, r_a} + {1'b0, w_imm};
    assign w_sum_b     = {1'b0, r_b} + {1'b0, w_imm};
    assign w_step_rise = bus.step & ~r_step_q;
    assign w_exec      = ~r_halted & (bus.run | w_step_rise);

    // Instruction semantics: compute every next-state value for the
    // fetched opcode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_carry_nxt  = 1'b0;               // every non-ADD clears carry
        w_pc_nxt     = r_pc + ADDR_W'(1);  // wraps modulo 2^ADDR_W
        w_out_nxt    = r_out;
        w_halted_nxt = r_halted;
        case (w_op)
            OP_ADD_A: begin
                w_a_nxt     = w_sum_a[DATA_W-1:0];
                w_carry_nxt = w_sum_a[DATA_W];
            end
            OP_ADD_B: begin
                w_b_nxt     = w_sum_b[DATA_W-1:0];
                w_carry_nxt = w_sum_b[DATA_W];
            end
            OP_MOV_AI: w_a_nxt   = w_imm;
            OP_MOV_BI: w_b_nxt   = w_imm;
            OP_MOV_AB: w_a_nxt   = r_b;
            OP_MOV_BA: w_b_nxt   = r_a;
            OP_IN_A:   w_a_nxt   = bus.in_port;
            OP_IN_B:   w_b_nxt   = bus.in_port;
            OP_OUT_B:  w_out_nxt = r_b;
            OP_OUT_I:  w_out_nxt = w_imm;
            OP_JMP:    w_pc_nxt  = ADDR_W'(w_imm);
            OP_JNC: begin
                // Tests the carry left by the previous instruction.
                if (!r_carry) w_pc_nxt = ADDR_W'(w_imm);
            end
            OP_HLT: begin
                w_halted_nxt = 1'b1;
                w_pc_nxt     = r_pc;
            end
            default: ;                     // 1000/1010/1100 are NOPs
        endcase
    end

    // Core state register: reset wins, then halted gates execution.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register
        // samples pre-edge values, matching the hardware it describes.
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_pc     <= '0;
            r_out    <= '0;
            r_halted <= 1'b0;
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= bus.step;
            if (w_exec) begin
                r_a      <= w_a_nxt;
                r_b      <= w_b_nxt;
                r_carry  <= w_carry_nxt;
                r_pc     <= w_pc_nxt;
                r_out    <= w_out_nxt;
                r_halted <= w_halted_nxt;
            end
        end
    end

    // Program memory write port, independent of run state.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset so it maps onto RAM and a
        // loaded program survives rst.
        if (bus.prog_we) r_mem[bus.prog_addr] <= bus.prog_data;
    end

    assign bus.out_port = r_out;
    assign bus.pc       = r_pc;
    assign bus.carry    = r_carry;
    assign bus.halted   = r_halted;
endmodule
